sdram_word_bridge: RTL and testbench

Upstream adapter between the stack CPU's 16-bit word memory port and the 64-bit `sdram_*` slave port exported by the HPS system wrapper. It packs 16-bit word accesses into 64-bit line transactions with lane byte-enables. It keeps a one-line read buffer so sequential word reads within a line skip the SDRAM round trip, and it writes through on every store. Only one request is outstanding at a time.

---
 rtl/sdram_bridge_pkg.sv | 12 +
 rtl/sdram_line_buffer.sv | 40 ++++
 rtl/sdram_word_bridge.sv | 90 +++++++++
 tb/tb_sdram_word_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_bridge_pkg.sv
// sdram_bridge_pkg: shared state type, lane geometry and lane helpers for the SDRAM word bridge
package sdram_bridge_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} bridge_state_t;
  localparam int LANES = 4;
  localparam int LANE_W = 16;
  function automatic logic [2*LANES-1:0] lane_be(input logic [1:0] lane);
    return 8'b11 << {lane, 1'b0};
  endfunction
  function automatic logic [LANE_W-1:0] lane_word(input logic [LANES*LANE_W-1:0] line, input logic [1:0] lane);
    return line[lane*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/sdram_line_buffer.sv
// sdram_line_buffer: one-line read buffer with hit lookup, fill, single-lane update and invalidate
module sdram_line_buffer
  import sdram_bridge_pkg::*;
#(
  parameter int TAG_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TAG_W-1:0]         look_tag,
  input  logic [1:0]               look_lane,
  output logic                     hit,
  output logic [LANE_W-1:0]        look_word,
  input  logic                     fill,
  input  logic [LANES*LANE_W-1:0]  fill_data,
  input  logic                     upd,
  input  logic [1:0]               upd_lane,
  input  logic [LANE_W-1:0]        upd_word,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic                     inval
);
  logic                    valid;
  logic [TAG_W-1:0]        tag;
  logic [LANES*LANE_W-1:0] data;
  assign hit = valid && tag == look_tag && !inval;
  assign look_word = lane_word(data, look_lane);
  // a fill outranks a coincident invalidate so the freshly loaded line survives
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= 1'b0;
      tag <= '0;
      data <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag <= wr_tag;
      data <= fill_data;
    end else begin
      if (inval) valid <= 1'b0;
      if (upd && valid && tag == wr_tag) data[upd_lane*LANE_W +: LANE_W] <= upd_word;
    end
endmodule

// File: rtl/sdram_word_bridge.sv
// sdram_word_bridge: packs 16-bit CPU word accesses into 64-bit SDRAM line transactions
// with a one-line read buffer and write-through stores
module sdram_word_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int CPU_ADDR_W   = 18,
  parameter int SDRAM_ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_valid,
  input  logic                     cpu_we,
  input  logic [CPU_ADDR_W-1:0]    cpu_addr,
  input  logic [LANE_W-1:0]        cpu_wdata,
  input  logic                     inval,
  output logic                     cpu_ready,
  output logic                     cpu_rvalid,
  output logic [LANE_W-1:0]        cpu_rdata,
  output logic [SDRAM_ADDR_W-1:0]  sdram_address,
  output logic [2*LANES-1:0]       sdram_byte_enable,
  output logic                     sdram_read,
  output logic                     sdram_write,
  output logic [LANES*LANE_W-1:0]  sdram_write_data,
  input  logic                     sdram_acknowledge,
  input  logic [LANES*LANE_W-1:0]  sdram_read_data
);
  bridge_state_t           state, state_nx;
  logic [1:0]              lane;
  logic [SDRAM_ADDR_W-1:0] line;
  logic                    accept, ack_rd, ack_wr, hit;
  logic [LANE_W-1:0]       hit_word;
  assign line   = cpu_addr[CPU_ADDR_W-1:2];
  assign accept = cpu_valid && cpu_ready;
  assign ack_rd = state == RD_WAIT && sdram_acknowledge;
  assign ack_wr = state == WR_WAIT && sdram_acknowledge;
  sdram_line_buffer #(.TAG_W(SDRAM_ADDR_W)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .look_tag  (line),
    .look_lane (cpu_addr[1:0]),
    .hit       (hit),
    .look_word (hit_word),
    .fill      (ack_rd),
    .fill_data (sdram_read_data),
    .upd       (ack_wr),
    .upd_lane  (lane),
    .upd_word  (sdram_write_data[LANE_W-1:0]),
    .wr_tag    (sdram_address),
    .inval     (inval)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (accept ? (cpu_we ? WR_WAIT : hit ? IDLE : RD_WAIT) : IDLE)
                             : (sdram_acknowledge ? IDLE : state);
  always_comb cpu_ready = state == IDLE && !reset;
  // request registers are only loaded on acceptance, so they hold through the ack cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata <= '0;
      sdram_address <= '0;
      sdram_byte_enable <= '0;
      sdram_read <= 1'b0;
      sdram_write <= 1'b0;
      sdram_write_data <= '0;
      lane <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      if (accept && !cpu_we && hit) begin
        cpu_rvalid <= 1'b1;
        cpu_rdata <= hit_word;
      end
      if (accept && (cpu_we || !hit)) begin
        sdram_address <= line;
        lane <= cpu_addr[1:0];
        sdram_read <= !cpu_we;
        sdram_write <= cpu_we;
        sdram_byte_enable <= cpu_we ? lane_be(cpu_addr[1:0]) : 8'hFF;
      end
      if (accept && cpu_we) sdram_write_data <= {LANES{cpu_wdata}};
      if (ack_rd) begin
        sdram_read <= 1'b0;
        cpu_rvalid <= 1'b1;
        cpu_rdata <= lane_word(sdram_read_data, lane);
      end
      if (ack_wr) sdram_write <= 1'b0;
    end
endmodule

// File: tb/tb_sdram_word_bridge.sv
// tb_sdram_word_bridge: directed and randomized checks of the word bridge against a line-memory model
module tb_sdram_word_bridge;
  logic        clk = 1'b0, reset = 1'b1, cpu_valid = 1'b0, cpu_we = 1'b0, inval = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        sdram_acknowledge = 1'b0;
  logic [63:0] sdram_read_data = '0;
  logic        cpu_ready, cpu_rvalid, sdram_read, sdram_write;
  logic [15:0] cpu_rdata, sdram_address;
  logic [7:0]  sdram_byte_enable;
  logic [63:0] sdram_write_data;
  int vecs = 0, errs = 0;
  logic [63:0] line10, line20;
  logic [63:0] mem [8];

  always #5 clk = ~clk;

  sdram_word_bridge dut (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .inval(inval), .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .sdram_address(sdram_address), .sdram_byte_enable(sdram_byte_enable),
    .sdram_read(sdram_read), .sdram_write(sdram_write), .sdram_write_data(sdram_write_data),
    .sdram_acknowledge(sdram_acknowledge), .sdram_read_data(sdram_read_data)
  );

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [15:0] ln, input logic [1:0] ls, input logic [15:0] wd);
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = {ln, ls}; cpu_wdata = wd;
    step;
    cpu_valid = 1'b0;
  endtask

  // counts request-strobe cycles up to and including the ack cycle
  task automatic serve(input int dly, input logic [63:0] rd, input logic inv, output int cnt);
    cnt = 0;
    for (int i = 0; i < dly; i++) begin
      if (sdram_read || sdram_write) cnt++;
      step;
    end
    sdram_acknowledge = 1'b1; sdram_read_data = rd; inval = inv;
    if (sdram_read || sdram_write) cnt++;
    step;
    sdram_acknowledge = 1'b0; inval = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) step;
    vecs++; if (cpu_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b exp 0", cpu_ready); end
    vecs++; if ({cpu_rvalid, cpu_rdata, sdram_read, sdram_write, sdram_address, sdram_byte_enable, sdram_write_data} !== '0) begin
      errs++; $display("FAIL reset_outputs got rv=%b rd=%h r=%b w=%b a=%h be=%h wd=%h", cpu_rvalid, cpu_rdata, sdram_read, sdram_write, sdram_address, sdram_byte_enable, sdram_write_data);
    end
    reset = 1'b0;
    #1;
    vecs++; if (cpu_ready !== 1'b1) begin errs++; $display("FAIL release_ready got %b exp 1", cpu_ready); end
    step;
  endtask

  task automatic test_read_miss;
    int cnt;
    line10 = 64'h4444_3333_2222_1111;
    issue(1'b0, 16'h0010, 2'd2, 16'h0);
    vecs++; if ({sdram_read, sdram_address, sdram_byte_enable} !== {1'b1, 16'h0010, 8'hFF}) begin
      errs++; $display("FAIL miss_request got r=%b a=%h be=%h exp r=1 a=0010 be=ff", sdram_read, sdram_address, sdram_byte_enable);
    end
    vecs++; if (cpu_ready !== 1'b0) begin errs++; $display("FAIL miss_busy_ready got %b exp 0", cpu_ready); end
    serve(3, line10, 1'b0, cnt);
    vecs++; if (cnt != 4) begin errs++; $display("FAIL miss_strobe_cycles got %0d exp 4", cnt); end
    vecs++; if ({sdram_read, cpu_rvalid, cpu_ready} !== 3'b011) begin
      errs++; $display("FAIL miss_done got r=%b rv=%b rdy=%b exp 0 1 1", sdram_read, cpu_rvalid, cpu_ready);
    end
    vecs++; if (cpu_rdata !== 16'h3333) begin errs++; $display("FAIL miss_rdata got %h exp 3333", cpu_rdata); end
    step;
    vecs++; if ({cpu_rvalid, cpu_rdata} !== {1'b0, 16'h3333}) begin
      errs++; $display("FAIL rdata_hold got rv=%b rd=%h exp rv=0 rd=3333", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_hits;
    logic [1:0] ls;
    cpu_valid = 1'b1; cpu_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ls = (k == 2) ? 2'd3 : 2'(k);
      cpu_addr = {16'h0010, ls};
      step;
      vecs++; if ({cpu_rvalid, cpu_rdata, sdram_read, sdram_write, cpu_ready} !== {1'b1, line10[ls*16 +: 16], 2'b00, 1'b1}) begin
        errs++; $display("FAIL hit_lane%0d got rv=%b rd=%h r=%b w=%b rdy=%b exp rd=%h", ls, cpu_rvalid, cpu_rdata, sdram_read, sdram_write, cpu_ready, line10[ls*16 +: 16]);
      end
    end
    cpu_valid = 1'b0;
    step;
  endtask

  task automatic test_write;
    int cnt;
    issue(1'b1, 16'h0010, 2'd1, 16'hABCD);
    vecs++; if ({sdram_write, sdram_read, sdram_address, sdram_byte_enable} !== {2'b10, 16'h0010, 8'h0C}) begin
      errs++; $display("FAIL wr_request got w=%b r=%b a=%h be=%h exp w=1 r=0 a=0010 be=0c", sdram_write, sdram_read, sdram_address, sdram_byte_enable);
    end
    vecs++; if (sdram_write_data !== 64'hABCD_ABCD_ABCD_ABCD) begin errs++; $display("FAIL wr_data got %h exp abcdabcdabcdabcd", sdram_write_data); end
    serve(2, 64'h0, 1'b0, cnt);
    vecs++; if (cnt != 3) begin errs++; $display("FAIL wr_strobe_cycles got %0d exp 3", cnt); end
    vecs++; if ({sdram_write, cpu_rvalid, cpu_ready} !== 3'b001) begin
      errs++; $display("FAIL wr_done got w=%b rv=%b rdy=%b exp 0 0 1", sdram_write, cpu_rvalid, cpu_ready);
    end
    line10[31:16] = 16'hABCD;
    issue(1'b0, 16'h0010, 2'd1, 16'h0);
    vecs++; if ({cpu_rvalid, cpu_rdata, sdram_read} !== {1'b1, 16'hABCD, 1'b0}) begin
      errs++; $display("FAIL wr_then_hit got rv=%b rd=%h r=%b exp 1 abcd 0", cpu_rvalid, cpu_rdata, sdram_read);
    end
  endtask

  task automatic test_inval;
    int cnt;
    inval = 1'b1; step; inval = 1'b0;
    issue(1'b0, 16'h0010, 2'd0, 16'h0);
    vecs++; if ({sdram_read, cpu_rvalid} !== 2'b10) begin errs++; $display("FAIL inval_miss got r=%b rv=%b exp 1 0", sdram_read, cpu_rvalid); end
    serve(0, line10, 1'b0, cnt);
    vecs++; if ({cnt == 1, cpu_rvalid, cpu_rdata} !== {2'b11, 16'h1111}) begin
      errs++; $display("FAIL min_latency got cnt=%0d rv=%b rd=%h exp 1 1 1111", cnt, cpu_rvalid, cpu_rdata);
    end
    line20 = {$urandom, $urandom};
    issue(1'b0, 16'h0020, 2'd3, 16'h0);
    vecs++; if (sdram_read !== 1'b1) begin errs++; $display("FAIL line20_miss got r=%b exp 1", sdram_read); end
    serve(1, line20, 1'b1, cnt);
    vecs++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, line20[63:48]}) begin
      errs++; $display("FAIL fill_inval_rdata got rv=%b rd=%h exp 1 %h", cpu_rvalid, cpu_rdata, line20[63:48]);
    end
    issue(1'b0, 16'h0020, 2'd0, 16'h0);
    vecs++; if ({cpu_rvalid, cpu_rdata, sdram_read} !== {1'b1, line20[15:0], 1'b0}) begin
      errs++; $display("FAIL fill_wins_hit got rv=%b rd=%h r=%b exp 1 %h 0", cpu_rvalid, cpu_rdata, sdram_read, line20[15:0]);
    end
  endtask

  task automatic test_reset_mid;
    int cnt;
    issue(1'b0, 16'h0030, 2'd1, 16'h0);
    vecs++; if (sdram_read !== 1'b1) begin errs++; $display("FAIL mid_miss got r=%b exp 1", sdram_read); end
    #2 reset = 1'b1;
    #1;
    vecs++; if ({sdram_read, cpu_ready} !== 2'b00) begin errs++; $display("FAIL async_reset got r=%b rdy=%b exp 0 0", sdram_read, cpu_ready); end
    step; step;
    reset = 1'b0;
    step;
    vecs++; if ({cpu_rvalid, sdram_read, cpu_ready} !== 3'b001) begin
      errs++; $display("FAIL post_reset got rv=%b r=%b rdy=%b exp 0 0 1", cpu_rvalid, sdram_read, cpu_ready);
    end
    issue(1'b0, 16'h0020, 2'd2, 16'h0);
    vecs++; if ({sdram_read, cpu_rvalid} !== 2'b10) begin errs++; $display("FAIL post_reset_miss got r=%b rv=%b exp 1 0", sdram_read, cpu_rvalid); end
    serve(0, line20, 1'b0, cnt);
    vecs++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, line20[47:32]}) begin
      errs++; $display("FAIL post_reset_rdata got rv=%b rd=%h exp 1 %h", cpu_rvalid, cpu_rdata, line20[47:32]);
    end
  endtask

  task automatic test_spurious_ack;
    sdram_acknowledge = 1'b1; sdram_read_data = 64'hDEAD_BEEF_DEAD_BEEF;
    step; step;
    vecs++; if ({cpu_rvalid, sdram_read, sdram_write, cpu_ready} !== 4'b0001) begin
      errs++; $display("FAIL spurious_ack got rv=%b r=%b w=%b rdy=%b exp 0 0 0 1", cpu_rvalid, sdram_read, sdram_write, cpu_ready);
    end
    sdram_acknowledge = 1'b0;
    issue(1'b0, 16'h0020, 2'd1, 16'h0);
    vecs++; if ({cpu_rvalid, cpu_rdata, sdram_read} !== {1'b1, line20[31:16], 1'b0}) begin
      errs++; $display("FAIL spurious_then_hit got rv=%b rd=%h r=%b exp 1 %h 0", cpu_rvalid, cpu_rdata, sdram_read, line20[31:16]);
    end
  endtask

  // model: SDRAM is an array of lines; the buffer is just (valid, line) since write-through keeps it equal to memory
  task automatic test_random;
    int r, idx, dly, cnt;
    logic [1:0] ls;
    logic [15:0] ln, wd;
    logic bv, exp_hit;
    logic [15:0] bl;
    for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
    inval = 1'b1; step; inval = 1'b0;
    bv = 1'b0; bl = '0;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9); idx = $urandom_range(0, 7); ls = 2'($urandom_range(0, 3));
      ln = 16'h0100 + 16'(idx); dly = $urandom_range(0, 3);
      if (r == 0) begin
        inval = 1'b1; step; inval = 1'b0; bv = 1'b0;
      end else if (r < 4) begin
        wd = 16'($urandom);
        issue(1'b1, ln, ls, wd);
        vecs++; if ({sdram_write, sdram_address, sdram_byte_enable, sdram_write_data} !== {1'b1, ln, 8'(8'h3 << (2 * ls)), {4{wd}}}) begin
          errs++; $display("FAIL rnd_write n=%0d got w=%b a=%h be=%h wd=%h exp a=%h lane=%0d wd=%h", n, sdram_write, sdram_address, sdram_byte_enable, sdram_write_data, ln, ls, wd);
        end
        serve(dly, 64'h0, 1'b0, cnt);
        vecs++; if ({cnt == dly + 1, sdram_write, cpu_rvalid} !== 3'b100) begin
          errs++; $display("FAIL rnd_write_done n=%0d got cnt=%0d w=%b rv=%b exp cnt=%0d", n, cnt, sdram_write, cpu_rvalid, dly + 1);
        end
        mem[idx][ls*16 +: 16] = wd;
      end else begin
        exp_hit = bv && bl == ln;
        issue(1'b0, ln, ls, 16'h0);
        vecs++; if ({cpu_rvalid, sdram_read} !== {exp_hit, !exp_hit}) begin
          errs++; $display("FAIL rnd_hitmiss n=%0d got rv=%b r=%b exp hit=%b", n, cpu_rvalid, sdram_read, exp_hit);
        end
        if (sdram_read) begin
          vecs++; if ({sdram_address, sdram_byte_enable} !== {ln, 8'hFF}) begin
            errs++; $display("FAIL rnd_miss_req n=%0d got a=%h be=%h exp a=%h be=ff", n, sdram_address, sdram_byte_enable, ln);
          end
          serve(dly, mem[idx], 1'b0, cnt);
        end
        vecs++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, mem[idx][ls*16 +: 16]}) begin
          errs++; $display("FAIL rnd_rdata n=%0d got rv=%b rd=%h exp 1 %h", n, cpu_rvalid, cpu_rdata, mem[idx][ls*16 +: 16]);
        end
        bv = 1'b1; bl = ln;
      end
    end
  endtask

  initial begin
    test_reset;
    test_read_miss;
    test_hits;
    test_write;
    test_inval;
    test_reset_mid;
    test_spurious_ack;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
